// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
//   lsu_state_t : access FSM states
//   lsu_size_t  : decoded access size/sign
//   size_decode : size flags -> lsu_size_t (fixed priority)
//   be_gen      : byte enables for a size and address offset
package mem_lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;
    typedef enum logic [2:0] {SZ_B, SZ_BU, SZ_H, SZ_HU, SZ_W} lsu_size_t;

    // Priority: full_word > half_word > half_wordU > byte > byteU; none = word.
    function automatic lsu_size_t size_decode(input logic b, input logic h, input logic w,
                                              input logic bu, input logic hu);
        if (w)       return SZ_W;
        else if (h)  return SZ_H;
        else if (hu) return SZ_HU;
        else if (b)  return SZ_B;
        else if (bu) return SZ_BU;
        else         return SZ_W;
    endfunction

    function automatic logic [3:0] be_gen(input lsu_size_t sz, input logic [1:0] off);
        case (sz)
            SZ_B, SZ_BU: return 4'b0001 << off;
            SZ_H, SZ_HU: return 4'b0011 << {off[1], 1'b0};
            default:     return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for the LSU.
//   st_size_i/st_off_i/st_data_i : current store size, addr[1:0], rs2 data
//   st_be_o/st_wdata_o           : byte enables, lane-replicated store data
//   ld_size_i/ld_off_i/rdata_i   : latched load size, addr[1:0], bus read data
//   ld_data_o                    : sign/zero-extended load result
module lsu_align
    import mem_lsu_pkg::*;
(
    input  lsu_size_t   st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  lsu_size_t   ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] lane;

    always_comb begin
        st_be_o = be_gen(st_size_i, st_off_i);
        case (st_size_i)
            SZ_B, SZ_BU: st_wdata_o = {4{st_data_i[7:0]}};
            SZ_H, SZ_HU: st_wdata_o = {2{st_data_i[15:0]}};
            default:     st_wdata_o = st_data_i;
        endcase
    end

    always_comb begin
        lane = rdata_i >> {ld_off_i, 3'b000};
        case (ld_size_i)
            SZ_B:    ld_data_o = {{24{lane[7]}}, lane[7:0]};
            SZ_BU:   ld_data_o = {24'b0, lane[7:0]};
            SZ_H:    ld_data_o = {{16{lane[15]}}, lane[15:0]};
            SZ_HU:   ld_data_o = {16'b0, lane[15:0]};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns the EX/MEM access request into a single
// data-memory bus transaction and stalls the pipeline until it completes.
//   MEM_clk/MEM_rst        : clock, async active-high reset
//   ALU_out_M, reg_read_data_2_M, mem_read_M, mem_write_M, size flags : request
//   stall_M                : hold pipeline while the access is in flight
//   load_data_M            : registered extended load data
//   bus_err_M              : one-cycle pulse in DONE on watchdog timeout
//   dmem_*                 : data-memory bus (req/we/addr/be/wdata out, gnt/rvalid/rdata in)
//   misalign_M             : only with MEM_MISALIGN_TRAP_EN; pulse in DONE on a
//                            misaligned half/word access, which skips the bus
module mem_stage_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic        MEM_clk,
    input  logic        MEM_rst,
    input  logic [31:0] ALU_out_M,
    input  logic [31:0] reg_read_data_2_M,
    input  logic        mem_read_M,
    input  logic        mem_write_M,
    input  logic        byte_M,
    input  logic        half_word_M,
    input  logic        full_word_M,
    input  logic        byteU_M,
    input  logic        half_wordU_M,
    output logic        stall_M,
    output logic [31:0] load_data_M,
    output logic        bus_err_M,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_M,
`endif
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    lsu_state_t      state_q;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            wd_expired;
    lsu_size_t       cur_size, ld_size_q;
    logic [1:0]      ld_off_q;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata, ld_ext;
    logic            access;

    assign access     = mem_read_M | mem_write_M;
    assign stall_M    = access & (state_q != DONE);
    assign cur_size   = size_decode(byte_M, half_word_M, full_word_M, byteU_M, half_wordU_M);
    assign wd_d       = wd_q + TO_W'(1);
    // Current waiting cycle is the TIMEOUT_CYC-th one with no response.
    assign wd_expired = (wd_d == TO_W'(TIMEOUT_CYC));

`ifdef MEM_MISALIGN_TRAP_EN
    logic misal;
    logic misalign_q;
    assign misal = (((cur_size == SZ_H) || (cur_size == SZ_HU)) && ALU_out_M[0]) ||
                   ((cur_size == SZ_W) && (ALU_out_M[1:0] != 2'b00));
    assign misalign_M = misalign_q;
`endif

    // Load extraction uses the size/offset latched at request time so the
    // result is independent of whatever sits on the EX/MEM inputs later.
    lsu_align u_align (
        .st_size_i  (cur_size),
        .st_off_i   (ALU_out_M[1:0]),
        .st_data_i  (reg_read_data_2_M),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .ld_size_i  (ld_size_q),
        .ld_off_i   (ld_off_q),
        .rdata_i    (dmem_rdata),
        .ld_data_o  (ld_ext)
    );

    always_ff @(posedge MEM_clk or posedge MEM_rst) begin
        if (MEM_rst) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            ld_size_q   <= SZ_B;
            ld_off_q    <= 2'b00;
            load_data_M <= '0;
            bus_err_M   <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            dmem_wdata  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            bus_err_M <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: if (access) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misal) begin
                        state_q    <= DONE;
                        misalign_q <= 1'b1;
                    end else
`endif
                    begin
                        state_q    <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_M;
                        dmem_addr  <= {ALU_out_M[31:2], 2'b00};
                        dmem_be    <= st_be;
                        dmem_wdata <= st_wdata;
                        ld_size_q  <= cur_size;
                        ld_off_q   <= ALU_out_M[1:0];
                        wd_q       <= '0;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        wd_q     <= '0;
                        state_q  <= dmem_we ? DONE : RESP;
                    end else if (wd_expired) begin
                        dmem_req  <= 1'b0;
                        bus_err_M <= 1'b1;
                        state_q   <= DONE;
                        if (!dmem_we) load_data_M <= '0;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        load_data_M <= ld_ext;
                        state_q     <= DONE;
                    end else if (wd_expired) begin
                        load_data_M <= '0;
                        bus_err_M   <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    localparam int TO = 4;
    localparam int MB = 0, MBU = 1, MH = 2, MHU = 3, MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_out_M, reg_read_data_2_M;
    logic        mem_read_M, mem_write_M;
    logic        byte_M, half_word_M, full_word_M, byteU_M, half_wordU_M;
    logic        stall_M, bus_err_M;
    logic [31:0] load_data_M;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_M;
`endif

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYC(TO)) dut (
        .MEM_clk(clk), .MEM_rst(rst),
        .ALU_out_M(ALU_out_M), .reg_read_data_2_M(reg_read_data_2_M),
        .mem_read_M(mem_read_M), .mem_write_M(mem_write_M),
        .byte_M(byte_M), .half_word_M(half_word_M), .full_word_M(full_word_M),
        .byteU_M(byteU_M), .half_wordU_M(half_wordU_M),
        .stall_M(stall_M), .load_data_M(load_data_M), .bus_err_M(bus_err_M),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_M(misalign_M),
`endif
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    int          n_chk = 0, n_err = 0;
    logic [31:0] ld_model = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- reference model: plain arithmetic from the access rules ----
    // fl = {full_word, half_word, half_wordU, byte, byteU}
    function automatic int sz_of(input logic [4:0] fl);
        if (fl[4]) return MW;
        if (fl[3]) return MH;
        if (fl[2]) return MHU;
        if (fl[1]) return MB;
        if (fl[0]) return MBU;
        return MW;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
        int o;
        o = int'(a[1:0]);
        if (sz == MB || sz == MBU) return 4'(1 << o);
        if (sz == MH || sz == MHU) return 4'(3 << (2 * (o / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
        if (sz == MB || sz == MBU) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == MH || sz == MHU) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] lane, v;
        lane = r >> (8 * int'(a[1:0]));
        case (sz)
            MB:  begin v = lane & 32'hFF;   return (v ^ 32'h80) - 32'h80; end
            MBU: return lane & 32'hFF;
            MH:  begin v = lane & 32'hFFFF; return (v ^ 32'h8000) - 32'h8000; end
            MHU: return lane & 32'hFFFF;
            default: return r;
        endcase
    endfunction

    // Drives one access from just after a rising edge until the cycle after
    // DONE. gdly = REQ cycles before gnt, rdly = RESP cycles before rvalid.
    task automatic do_access(input string tag, input bit wr, input bit rd, input logic [4:0] fl,
                             input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                             input int gdly, input int rdly);
        int  sz, req_exp, stall_exp, stall_n, req_n, resp_i;
        bit  err_exp, done;
        sz      = sz_of(fl);
        req_exp = (gdly < TO) ? gdly + 1 : TO;
        err_exp = (gdly >= TO) || (!wr && rdly >= TO);
        stall_exp = 1 + req_exp;
        if (!wr && gdly < TO) stall_exp += (rdly < TO) ? rdly + 1 : TO;
        if (!wr) ld_model = err_exp ? 32'h0 : m_load(sz, a, rdat);

        ALU_out_M = a; reg_read_data_2_M = d; mem_write_M = wr; mem_read_M = rd;
        {full_word_M, half_word_M, half_wordU_M, byte_M, byteU_M} = fl;
        stall_n = 0; req_n = 0; resp_i = -1; done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (!stall_M) begin done = 1; break; end
            stall_n++;
            if (resp_i >= 0) begin
                dmem_gnt    = 1'($urandom);   // gnt outside REQ must be ignored
                dmem_rvalid = (resp_i == rdly);
                dmem_rdata  = (resp_i == rdly) ? rdat : $urandom;
                resp_i++;
            end else if (dmem_req) begin
                if (req_n == 0) begin
                    chk({tag, " addr"}, dmem_addr, a & 32'hFFFF_FFFC);
                    chk({tag, " be"}, 32'(dmem_be), 32'(m_be(sz, a)));
                    chk({tag, " we"}, 32'(dmem_we), 32'(wr));
                    if (wr) chk({tag, " wdata"}, dmem_wdata, m_wdata(sz, d));
                end
                req_n++;
                dmem_rvalid = 1'($urandom);   // rvalid in REQ must be ignored
                dmem_rdata  = $urandom;
                if (req_n - 1 == gdly) begin
                    dmem_gnt = 1'b1;
                    if (!wr) resp_i = 0;
                end
            end
        end
        if (!done) chk({tag, " done-timeout"}, 32'(stall_M), 32'h0);
        chk({tag, " stall_cyc"}, 32'(stall_n), 32'(stall_exp));
        chk({tag, " req_cyc"}, 32'(req_n), 32'(req_exp));
        chk({tag, " bus_err"}, 32'(bus_err_M), 32'(err_exp));
        chk({tag, " req_done"}, 32'(dmem_req), 32'h0);
        chk({tag, " load_data"}, load_data_M, ld_model);
        @(posedge clk); #1;
        mem_read_M = 1'b0; mem_write_M = 1'b0;
        chk({tag, " err_pulse"}, 32'(bus_err_M), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        ALU_out_M = 0; reg_read_data_2_M = 0; mem_read_M = 0; mem_write_M = 0;
        {full_word_M, half_word_M, half_wordU_M, byte_M, byteU_M} = 5'b0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        #2;
        chk("rst req", 32'(dmem_req), 0);
        chk("rst we", 32'(dmem_we), 0);
        chk("rst addr", dmem_addr, 0);
        chk("rst be", 32'(dmem_be), 0);
        chk("rst wdata", dmem_wdata, 0);
        chk("rst load", load_data_M, 0);
        chk("rst err", 32'(bus_err_M), 0);
        chk("rst stall", 32'(stall_M), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // directed cases
        do_access("sw",   1, 0, 5'b10000, 32'h100, 32'hDEADBEEF, 0, 0, 0);
        do_access("lb",   0, 1, 5'b00010, 32'h103, 0, 32'h80FF_0000, 0, 0);
        do_access("lbu",  0, 1, 5'b00001, 32'h103, 0, 32'h80FF_0000, 0, 0);
        do_access("sh",   1, 0, 5'b01000, 32'h102, 32'h1234ABCD, 0, 0, 0);
        do_access("lh",   0, 1, 5'b01000, 32'h102, 0, 32'h8001_7FFF, 1, 2);
        do_access("gto",  0, 1, 5'b10000, 32'h104, 0, 32'h5555_5555, 9, 0);
        do_access("lw",   0, 1, 5'b00000, 32'h108, 0, 32'hCAFE_F00D, 0, 0);
        do_access("rto",  0, 1, 5'b00100, 32'h10A, 0, 32'h1111_2222, 1, 9);
        do_access("swto", 1, 1, 5'b00010, 32'h10C, 32'h77, 0, 9, 0);

        // reset while waiting for read data
        ALU_out_M = 32'h200; mem_read_M = 1'b1;
        {full_word_M, half_word_M, half_wordU_M, byte_M, byteU_M} = 5'b00010;
        @(negedge clk);                       // IDLE
        @(negedge clk);                       // REQ
        chk("mr req", 32'(dmem_req), 1);
        dmem_gnt = 1'b1;
        @(negedge clk);                       // RESP
        dmem_gnt = 1'b0;
        rst = 1'b1; #1;
        chk("mr req0", 32'(dmem_req), 0);
        chk("mr load0", load_data_M, 0);
        chk("mr err0", 32'(bus_err_M), 0);
        mem_read_M = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr late rv", load_data_M, 0);
        chk("mr stall", 32'(stall_M), 0);
        chk("mr req1", 32'(dmem_req), 0);
        dmem_rvalid = 1'b0;
        ld_model = 32'h0;
        @(posedge clk); #1;
        do_access("post", 0, 1, 5'b00001, 32'h201, 0, 32'h0000_9A00, 0, 1);

`ifdef MEM_MISALIGN_TRAP_EN
        ALU_out_M = 32'h101; mem_read_M = 1'b1;
        {full_word_M, half_word_M, half_wordU_M, byte_M, byteU_M} = 5'b10000;
        @(negedge clk);
        chk("mis stall", 32'(stall_M), 1);
        @(negedge clk);
        chk("mis done", 32'(stall_M), 0);
        chk("mis pulse", 32'(misalign_M), 1);
        chk("mis req", 32'(dmem_req), 0);
        chk("mis load", load_data_M, ld_model);
        @(posedge clk); #1 mem_read_M = 1'b0;
        chk("mis clr", 32'(misalign_M), 0);
`endif

        // randomized accesses
        for (int i = 0; i < 60; i++) begin
            bit          wr, rd;
            int          k, g, r;
            logic [4:0]  fl;
            logic [31:0] a;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            k  = $urandom_range(0, 6);
            fl = (k < 5) ? 5'(1 << k) : ((k == 5) ? 5'($urandom) : 5'b0);
            a  = 32'h1000 + 32'($urandom_range(0, 255));
`ifdef MEM_MISALIGN_TRAP_EN
            if (sz_of(fl) == MW) a[1:0] = 2'b00;
            if (sz_of(fl) == MH || sz_of(fl) == MHU) a[0] = 1'b0;
`endif
            g = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
            r = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
            do_access("rnd", wr, rd, fl, a, $urandom, $urandom, g, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
